pll_reset_sequencer: RTL and testbench



---
 rtl/pll_seq_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/pll_reset_sequencer.sv | 146 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } seq_state_t;

    // Smallest counter width that can hold the largest per-state limit.
    function automatic int cnt_width(input int rst_cycles, input int lock_timeout,
                                     input int stable_cycles);
        int m;
        m = rst_cycles;
        if (lock_timeout > m) m = lock_timeout;
        if (stable_cycles > m) m = stable_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low clear.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, qualifies lock, and releases the system reset once
// lock has been stable; re-arms the PLL on timeout or lock loss.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int LOSS_FILTER    = 4,
    parameter int MAX_RETRIES    = 7,
    parameter int CNT_W          = 16
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [2:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST    = CNT_W'(LOSS_FILTER - 1);
    localparam logic [2:0]       RETRY_MAX    = 3'(MAX_RETRIES);

    logic             w_locked_s;
    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_retry;
    logic [2:0]       w_retry_nxt;
    logic [7:0]       r_loss;
    logic [7:0]       w_loss_nxt;
    logic             r_pll_rst;
    logic             r_sys_rst_n;
    logic             r_ready;
    logic             r_fail;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .i_clk   (refclk),
        .i_rst_n (rst_n),
        .i_d     (pll_locked),
        .o_q     (w_locked_s)
    );

    // The shared counter restarts at zero on every state change; in RUN it
    // counts consecutive unlocked cycles instead of time in state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_retry_nxt = r_retry;
        w_loss_nxt  = r_loss;
        if (restart) begin
            w_state_nxt = ST_RESET_PLL;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
        end else begin
            case (r_state)
                ST_RESET_PLL: begin
                    if (r_cnt == RST_LAST) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        w_cnt_nxt = '0;
                        if (r_retry == RETRY_MAX) begin
                            w_state_nxt = ST_FAIL;
                        end else begin
                            w_state_nxt = ST_RESET_PLL;
                            w_retry_nxt = r_retry + 3'd1;
                        end
                    end
                end
                ST_STABLE: begin
                    if (!w_locked_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == STABLE_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                        w_retry_nxt = '0;
                    end
                end
                ST_RUN: begin
                    if (w_locked_s) begin
                        w_cnt_nxt = '0;
                    end else if (r_cnt == LOSS_LAST) begin
                        w_state_nxt = ST_RESET_PLL;
                        w_cnt_nxt   = '0;
                        w_loss_nxt  = (r_loss == 8'hFF) ? r_loss : r_loss + 8'd1;
                    end
                end
                ST_FAIL: begin
                    w_cnt_nxt = r_cnt;
                end
                default: begin
                    w_state_nxt = ST_RESET_PLL;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the transition that causes them.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RESET_PLL;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_loss      <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_loss      <= w_loss_nxt;
            r_pll_rst   <= (w_state_nxt == ST_RESET_PLL) || (w_state_nxt == ST_FAIL);
            r_sys_rst_n <= (w_state_nxt == ST_RUN);
            r_ready     <= (w_state_nxt == ST_RUN);
            r_fail      <= (w_state_nxt == ST_FAIL);
        end
    end

    assign pll_rst   = r_pll_rst;
    assign sys_rst_n = r_sys_rst_n;
    assign ready     = r_ready;
    assign fail      = r_fail;
    assign retry_cnt = r_retry;
    assign loss_cnt  = r_loss;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: a phase/age reference model
// compared every cycle, plus hand-computed latency and value checks.
module tb_pll_reset_sequencer;
    import pll_seq_pkg::*;

    localparam int PLL_RST_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 32;
    localparam int STABLE_CYCLES  = 8;
    localparam int LOSS_FILTER    = 3;
    localparam int MAX_RETRIES    = 2;
    localparam int CNT_W          = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [2:0] retry_cnt;
    logic [7:0] loss_cnt;

    int checks = 0;
    int errors = 0;
    bit cmpEn  = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (PLL_RST_CYCLES),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT),
        .STABLE_CYCLES  (STABLE_CYCLES),
        .LOSS_FILTER    (LOSS_FILTER),
        .MAX_RETRIES    (MAX_RETRIES),
        .CNT_W          (CNT_W)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Reference model: phase 0..4 = reset-pll, wait-lock, stable, run, fail.
    // m_age is cycles spent in the phase, m_bad consecutive unlocked cycles in run.
    int   m_ph, m_age, m_bad, m_retry, m_loss;
    logic m_s1, m_s2;

    task automatic modelEnter(input int ph);
        m_ph  = ph;
        m_age = 0;
        m_bad = 0;
    endtask

    always @(posedge refclk or negedge rst_n) begin
        logic ls;
        if (!rst_n) begin
            modelEnter(0);
            m_retry = 0;
            m_loss  = 0;
            m_s1    = 1'b0;
            m_s2    = 1'b0;
        end else begin
            ls   = m_s2;
            m_s2 = m_s1;
            m_s1 = pll_locked;
            if (restart) begin
                modelEnter(0);
                m_retry = 0;
            end else if (m_ph == 0) begin
                m_age++;
                if (m_age == PLL_RST_CYCLES) modelEnter(1);
            end else if (m_ph == 1) begin
                if (ls) modelEnter(2);
                else begin
                    m_age++;
                    if (m_age == LOCK_TIMEOUT) begin
                        if (m_retry == MAX_RETRIES) modelEnter(4);
                        else begin
                            m_retry++;
                            modelEnter(0);
                        end
                    end
                end
            end else if (m_ph == 2) begin
                if (!ls) modelEnter(1);
                else begin
                    m_age++;
                    if (m_age == STABLE_CYCLES) begin
                        modelEnter(3);
                        m_retry = 0;
                    end
                end
            end else if (m_ph == 3) begin
                m_bad = ls ? 0 : m_bad + 1;
                if (m_bad == LOSS_FILTER) begin
                    if (m_loss < 255) m_loss++;
                    modelEnter(0);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Every cycle, the DUT must agree with the model.
    always @(negedge refclk) begin
        if (cmpEn) begin
            checkOutput("cyc_pll_rst",   int'(pll_rst),   int'(m_ph == 0 || m_ph == 4));
            checkOutput("cyc_sys_rst_n", int'(sys_rst_n), int'(m_ph == 3));
            checkOutput("cyc_ready",     int'(ready),     int'(m_ph == 3));
            checkOutput("cyc_fail",      int'(fail),      int'(m_ph == 4));
            checkOutput("cyc_retry_cnt", int'(retry_cnt), m_retry);
            checkOutput("cyc_loss_cnt",  int'(loss_cnt),  m_loss);
        end
    end

    function automatic logic pickSignal(input int sel);
        case (sel)
            0:       return pll_rst;
            1:       return sys_rst_n;
            2:       return ready;
            default: return fail;
        endcase
    endfunction

    // Counts posedges until the selected output reaches val; sampled #1 after each edge.
    task automatic waitEdge(input int sel, input logic val, input int maxCyc, output int n);
        n = 0;
        while (1) begin
            @(posedge refclk);
            #1;
            n++;
            if (pickSignal(sel) == val) break;
            if (n >= maxCyc) begin
                checkOutput("wait_timeout", n, -1);
                break;
            end
        end
    endtask

    task automatic applyStimulus(input logic locked, input logic rst);
        pll_locked = locked;
        restart    = rst;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge refclk);
        cmpEn = 1;
        checkOutput("reset_pll_rst",   int'(pll_rst),   1);
        checkOutput("reset_sys_rst_n", int'(sys_rst_n), 0);
        checkOutput("reset_loss_cnt",  int'(loss_cnt),  0);

        $display("[TB] test 1: release and first lock");
        rst_n = 1'b1;
        waitEdge(0, 1'b0, 20, n);
        checkOutput("t1_pll_rst_cycles", n, PLL_RST_CYCLES);
        repeat (6) @(posedge refclk);
        #1 applyStimulus(1'b1, 1'b0);
        waitEdge(2, 1'b1, 60, n);
        // two synchronizer flops, one WAIT_LOCK observation edge, eight STABLE cycles
        checkOutput("t1_ready_latency", n, 11);
        checkOutput("t1_sys_rst_n", int'(sys_rst_n), 1);
        checkOutput("t1_retry_cnt", int'(retry_cnt), 0);

        $display("[TB] test 4: lock glitches in run");
        applyStimulus(1'b0, 1'b0);
        repeat (2) @(posedge refclk);
        #1 applyStimulus(1'b1, 1'b0);
        repeat (6) @(posedge refclk);
        #1;
        checkOutput("t4_glitch_ready", int'(ready), 1);
        checkOutput("t4_glitch_loss",  int'(loss_cnt), 0);
        applyStimulus(1'b0, 1'b0);
        n = 0;
        while (1) begin
            @(posedge refclk);
            #1;
            n++;
            if (n == 3) applyStimulus(1'b1, 1'b0);
            if (!sys_rst_n || n >= 20) break;
        end
        checkOutput("t4_loss_latency", n, 2 + LOSS_FILTER);
        checkOutput("t4_loss_cnt", int'(loss_cnt), 1);
        waitEdge(0, 1'b0, 20, n);
        checkOutput("t4_pll_rst_cycles", n, PLL_RST_CYCLES);
        waitEdge(2, 1'b1, 40, n);
        checkOutput("t4_relock_latency", n, 1 + STABLE_CYCLES);

        $display("[TB] test 3: lock drop during stable");
        @(negedge refclk);
        applyStimulus(1'b0, 1'b1);
        @(negedge refclk);
        applyStimulus(1'b0, 1'b0);
        waitEdge(0, 1'b0, 20, n);
        applyStimulus(1'b1, 1'b0);
        n = 0;
        while (1) begin
            @(posedge refclk);
            #1;
            n++;
            if (n == 6) applyStimulus(1'b0, 1'b0);
            if (n == 7) applyStimulus(1'b1, 1'b0);
            if (ready || n >= 40) break;
        end
        checkOutput("t3_release_latency", n, 18);

        $display("[TB] test 2: lock timeouts and fail");
        @(negedge refclk);
        applyStimulus(1'b0, 1'b1);
        @(posedge refclk);
        #1 applyStimulus(1'b0, 1'b0);
        waitEdge(3, 1'b1, 300, n);
        checkOutput("t2_fail_latency", n, (MAX_RETRIES + 1) * (PLL_RST_CYCLES + LOCK_TIMEOUT));
        checkOutput("t2_retry_cnt", int'(retry_cnt), MAX_RETRIES);
        checkOutput("t2_pll_rst",   int'(pll_rst),   1);
        checkOutput("t2_sys_rst_n", int'(sys_rst_n), 0);
        repeat (5) @(posedge refclk);
        #1;
        checkOutput("t2_fail_sticky", int'(fail), 1);
        @(negedge refclk);
        applyStimulus(1'b0, 1'b1);
        @(posedge refclk);
        #1 applyStimulus(1'b0, 1'b0);
        checkOutput("t2_restart_fail",  int'(fail),      0);
        checkOutput("t2_restart_retry", int'(retry_cnt), 0);
        checkOutput("t2_restart_rst",   int'(pll_rst),   1);

        $display("[TB] test 6: restart coincides with lock-loss threshold");
        applyStimulus(1'b1, 1'b0);
        waitEdge(2, 1'b1, 60, n);
        applyStimulus(1'b0, 1'b0);
        n = 0;
        while (n < 5) begin
            @(posedge refclk);
            #1;
            n++;
            if (n == 4) applyStimulus(1'b0, 1'b1);
            if (n == 5) applyStimulus(1'b0, 1'b0);
        end
        checkOutput("t6_loss_cnt",   int'(loss_cnt),  1);
        checkOutput("t6_pll_rst",    int'(pll_rst),   1);
        checkOutput("t6_sys_rst_n",  int'(sys_rst_n), 0);

        $display("[TB] test 5: asynchronous reset mid-run and mid-stable");
        applyStimulus(1'b1, 1'b0);
        waitEdge(2, 1'b1, 60, n);
        @(posedge refclk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_run_pll_rst",   int'(pll_rst),   1);
        checkOutput("t5_run_sys_rst_n", int'(sys_rst_n), 0);
        checkOutput("t5_run_ready",     int'(ready),     0);
        checkOutput("t5_run_loss_cnt",  int'(loss_cnt),  0);
        @(negedge refclk);
        rst_n = 1'b1;
        waitEdge(0, 1'b0, 20, n);
        repeat (3) @(posedge refclk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_stb_pll_rst",   int'(pll_rst),   1);
        checkOutput("t5_stb_retry_cnt", int'(retry_cnt), 0);
        checkOutput("t5_stb_fail",      int'(fail),      0);
        @(negedge refclk);
        rst_n = 1'b1;
        repeat (4) @(negedge refclk);

        cmpEn = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
